// File: rtl/topo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : topo_pkg
// Description : Shared constants, state encodings and helper functions for the
//               whack-a-mole controller (control_topos) and its LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
package topo_pkg;

    // Grid geometry: 3x3 cells, row-major, cell 0 top-left
    localparam int c_n_celdas = 9;
    localparam int c_grid_w   = 3;

    // Controller state encoding
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_spawn  = 2'd1;
    localparam logic [1:0] c_st_active = 2'd2;
    localparam logic [1:0] c_st_fin    = 2'd3;

    // 4-bit Fibonacci LFSR, x^4 + x^3 + 1 (feedback from bits 3 and 2)
    localparam logic [3:0] c_lfsr_seed = 4'b1001;
    localparam logic [3:0] c_lfsr_taps = 4'b1100;

    // Cursor home position (cell 4)
    localparam logic [c_n_celdas-1:0] c_center_onehot = 9'b000010000;

    // Row/column pair to linear cell index
    function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

    // Linear cell index to one-hot cell vector
    function automatic logic [c_n_celdas-1:0] cell_onehot(input logic [3:0] idx);
        return {{(c_n_celdas-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Fold the LFSR value onto the grid and avoid repeating the previous cell
    function automatic logic [3:0] spawn_index(input logic [3:0] lfsr, input logic [3:0] prev);
        logic [3:0] raw;
        raw = (lfsr < 4'd9) ? lfsr : (lfsr - 4'd9);
        if (raw == prev) begin
            raw = (raw == 4'd8) ? 4'd0 : (raw + 4'd1);
        end
        return raw;
    endfunction

    // Saturating binary increment
    function automatic logic [7:0] bin_inc_sat(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    // Saturating two-digit BCD increment (stops at 99)
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99) begin
            return v;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_topos_if.sv
`default_nettype none
// ============================================================================
// Module      : control_topos_if
// Description : Game-side signal bundle of the whack-a-mole controller:
//               player buttons, cell hit flags, mole/cursor/strike outputs
//               and score. master = board/cell side, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_topos_if;
    import topo_pkg::*;

    logic                  START;
    logic                  BTN_UP;
    logic                  BTN_DOWN;
    logic                  BTN_LEFT;
    logic                  BTN_RIGHT;
    logic                  BTN_GOLPE;
    logic [c_n_celdas-1:0] HIT;
    logic [c_n_celdas-1:0] PONER_TOPO;
    logic [c_n_celdas-1:0] SELECT;
    logic                  GOLPE;
    logic [7:0]            PUNTAJE;
    logic [7:0]            FALLOS;
    logic                  FIN_JUEGO;

    modport master (
        output START, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_GOLPE, HIT,
        input  PONER_TOPO, SELECT, GOLPE, PUNTAJE, FALLOS, FIN_JUEGO
    );

    modport slave (
        input  START, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_GOLPE, HIT,
        output PONER_TOPO, SELECT, GOLPE, PUNTAJE, FALLOS, FIN_JUEGO
    );

endinterface
`default_nettype wire

// File: rtl/lfsr_topo.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_topo
// Description : Free-running 4-bit Fibonacci LFSR (x^4 + x^3 + 1) used to
//               pick mole positions. Maximal length (15), never reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_topo
    import topo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] o_value
);

    logic [3:0] r_q;
    logic       w_fb;

    assign w_fb = ^(r_q & c_lfsr_taps);

    // Shift left every cycle, feedback enters at bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= c_lfsr_seed;
        end else begin
            r_q <= {r_q[2:0], w_fb};
        end
    end

    assign o_value = r_q;

endmodule
`default_nettype wire

// File: rtl/control_topos.sv
`default_nettype none
// ============================================================================
// Module      : control_topos
// Description : Whack-a-mole game controller for a 3x3 grid. Places one mole
//               at a time, times it out after TICKS_TOPO cycles, tracks the
//               player cursor, broadcasts strikes and keeps score/misses.
//               Optional macro PUNTAJE_BCD_EN: score as two BCD digits
//               saturating at 99 (default: binary saturating at 255).
// Revision    : 1.0 - initial release
// ============================================================================
module control_topos
    import topo_pkg::*;
#(
    parameter int TICKS_TOPO = 25000000,
    parameter int GAME_TOPOS = 30
) (
    input  logic           clk,
    input  logic           reset,
    control_topos_if.slave bus
);

    localparam int                  c_timer_w    = $clog2(TICKS_TOPO);
    localparam logic [c_timer_w-1:0] c_timer_load = c_timer_w'(TICKS_TOPO - 1);
    localparam logic [c_timer_w-1:0] c_timer_one  = c_timer_w'(1);
    localparam logic [7:0]          c_game_topos = 8'(GAME_TOPOS);

    logic [1:0]            r_state;
    logic [c_timer_w-1:0]  r_timer;
    logic [7:0]            r_count;
    logic [3:0]            r_prev_idx;
    logic [c_n_celdas-1:0] r_poner;
    logic                  r_golpe;
    logic [7:0]            r_puntaje;
    logic [7:0]            r_fallos;
    logic                  r_fin;
    logic [1:0]            r_row;
    logic [1:0]            r_col;
    logic [c_n_celdas-1:0] r_select;

    logic [3:0]            w_lfsr;
    logic [3:0]            w_idx;
    logic                  w_hit;
    logic                  w_expire;
    logic                  w_more;
    logic [7:0]            w_puntaje_inc;
    logic [1:0]            w_row_nxt;
    logic [1:0]            w_col_nxt;

    lfsr_topo u_lfsr (
        .clk     (clk),
        .rst     (reset),
        .o_value (w_lfsr)
    );

    assign w_idx    = spawn_index(w_lfsr, r_prev_idx);
    // Only the cell carrying the current mole can score a hit
    assign w_hit    = (r_state == c_st_active) && (|(bus.HIT & r_poner));
    assign w_expire = (r_state == c_st_active) && (r_timer == '0);
    assign w_more   = (r_count < c_game_topos);

`ifdef PUNTAJE_BCD_EN
    assign w_puntaje_inc = bcd_inc_sat(r_puntaje);
`else
    assign w_puntaje_inc = bin_inc_sat(r_puntaje);
`endif

    // Game sequencing: spawn, time out or score each mole, end after GAME_TOPOS
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_timer    <= '0;
            r_count    <= '0;
            r_prev_idx <= '0;
            r_poner    <= '0;
            r_puntaje  <= '0;
            r_fallos   <= '0;
            r_fin      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_fin: begin
                    r_poner <= '0;
                    if (bus.START) begin
                        r_state   <= c_st_spawn;
                        r_puntaje <= '0;
                        r_fallos  <= '0;
                        r_count   <= '0;
                        r_fin     <= 1'b0;
                    end
                end
                c_st_spawn: begin
                    r_poner    <= cell_onehot(w_idx);
                    r_prev_idx <= w_idx;
                    r_timer    <= c_timer_load;
                    r_count    <= r_count + 8'd1;
                    r_state    <= c_st_active;
                end
                c_st_active: begin
                    // A hit on the last tick still counts as a hit
                    if (w_hit) begin
                        r_puntaje <= w_puntaje_inc;
                    end else if (w_expire) begin
                        r_fallos <= bin_inc_sat(r_fallos);
                    end else begin
                        r_timer <= r_timer - c_timer_one;
                    end
                    if (w_hit || w_expire) begin
                        r_poner <= '0;
                        if (w_more) begin
                            r_state <= c_st_spawn;
                        end else begin
                            r_state <= c_st_fin;
                            r_fin   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_poner <= '0;
                end
            endcase
        end
    end

    // Strike pulse follows the button by one cycle, only while a mole is up
    always_ff @(posedge clk) begin
        if (reset) begin
            r_golpe <= 1'b0;
        end else begin
            r_golpe <= bus.BTN_GOLPE && (r_state == c_st_active);
        end
    end

    // Next cursor position: one wrapping move per cycle, UP > DOWN > LEFT > RIGHT
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (bus.BTN_UP) begin
            w_row_nxt = (r_row == 2'd0) ? 2'd2 : (r_row - 2'd1);
        end else if (bus.BTN_DOWN) begin
            w_row_nxt = (r_row == 2'd2) ? 2'd0 : (r_row + 2'd1);
        end else if (bus.BTN_LEFT) begin
            w_col_nxt = (r_col == 2'd0) ? 2'd2 : (r_col - 2'd1);
        end else if (bus.BTN_RIGHT) begin
            w_col_nxt = (r_col == 2'd2) ? 2'd0 : (r_col + 2'd1);
        end
    end

    // Cursor register; SELECT is re-encoded here so the output stays registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row    <= 2'd1;
            r_col    <= 2'd1;
            r_select <= c_center_onehot;
        end else begin
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            r_select <= cell_onehot(cell_index(w_row_nxt, w_col_nxt));
        end
    end

    assign bus.PONER_TOPO = r_poner;
    assign bus.SELECT     = r_select;
    assign bus.GOLPE      = r_golpe;
    assign bus.PUNTAJE    = r_puntaje;
    assign bus.FALLOS     = r_fallos;
    assign bus.FIN_JUEGO  = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_control_topos.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_topos
// Description : Self-checking bench for control_topos. Main instance runs
//               short games (8-cycle moles, 3 per game); a second instance
//               with every cell always reporting a hit plays 255 moles to
//               reach the score saturation value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_topos;
    import topo_pkg::*;

    localparam int TICKS = 8;
    localparam int GAMES = 3;
`ifdef PUNTAJE_BCD_EN
    localparam logic [7:0] SAT_EXP = 8'h99;
`else
    localparam logic [7:0] SAT_EXP = 8'hFF;
`endif

    typedef struct {
        logic [7:0] puntaje;
        logic [7:0] fallos;
        logic       fin;
        int         len;
    } exp_t;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic reset_sat = 1'b1;
    always #5 clk = ~clk;

    control_topos_if bus ();
    control_topos_if bus_sat ();

    // Cell model: a cell reports a hit when struck while selected and holding the mole
    logic [8:0] stray_hit = '0;
    assign bus.HIT     = (bus.GOLPE ? (bus.SELECT & bus.PONER_TOPO) : 9'd0) | stray_hit;
    assign bus_sat.HIT = 9'h1FF;

    control_topos #(.TICKS_TOPO(TICKS), .GAME_TOPOS(GAMES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    control_topos #(.TICKS_TOPO(TICKS), .GAME_TOPOS(255)) dut_sat (
        .clk   (clk),
        .reset (reset_sat),
        .bus   (bus_sat)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    bit   mon_en   = 1'b1;
    bit   sat_done = 1'b0;
    int   cur_row  = 1;
    int   cur_col  = 1;
    logic [8:0] prev_poner = '0;
    int   up_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every mole resolution is scored against the next queued expectation
    always @(negedge clk) begin
        if (mon_en && prev_poner != 9'd0 && bus.PONER_TOPO == 9'd0) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL resolve: unexpected mole resolution, PUNTAJE=%0h FALLOS=%0h", bus.PUNTAJE, bus.FALLOS);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_puntaje", 32'(bus.PUNTAJE), 32'(mon_e.puntaje));
                check("sb_fallos", 32'(bus.FALLOS), 32'(mon_e.fallos));
                check("sb_fin", 32'(bus.FIN_JUEGO), 32'(mon_e.fin));
                if (mon_e.len != 0) check("sb_mole_len", 32'(up_len), 32'(mon_e.len));
            end
        end
        up_len     = (bus.PONER_TOPO != 9'd0) ? up_len + 1 : 0;
        prev_poner = bus.PONER_TOPO;
    end

    task automatic push(input logic [7:0] p, input logic [7:0] f, input logic fin, input int len);
        exp_t e;
        e.puntaje = p; e.fallos = f; e.fin = fin; e.len = len;
        sb_q.push_back(e);
    endtask

    // One cycle of move pulses {up,down,left,right}; cursor model applies priority
    task automatic move(input logic [3:0] b);
        {bus.BTN_UP, bus.BTN_DOWN, bus.BTN_LEFT, bus.BTN_RIGHT} = b;
        if (b[3])      cur_row = (cur_row + 2) % 3;
        else if (b[2]) cur_row = (cur_row + 1) % 3;
        else if (b[1]) cur_col = (cur_col + 2) % 3;
        else if (b[0]) cur_col = (cur_col + 1) % 3;
        @(negedge clk);
        {bus.BTN_UP, bus.BTN_DOWN, bus.BTN_LEFT, bus.BTN_RIGHT} = 4'b0000;
        check("select_move", 32'(bus.SELECT), 32'(1) << (cur_row * 3 + cur_col));
    endtask

    task automatic pulse_start();
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic strike();
        bus.BTN_GOLPE = 1'b1;
        @(negedge clk);
        bus.BTN_GOLPE = 1'b0;
        check("golpe_pulse", 32'(bus.GOLPE), 32'd1);
    endtask

    task automatic wait_mole(output int idx);
        int n;
        n   = 0;
        idx = -1;
        while (bus.PONER_TOPO == 9'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.PONER_TOPO == 9'd0) begin
            n_checks++;
            $display("FAIL wait_mole: PONER_TOPO=%h expected a mole within 50 cycles", bus.PONER_TOPO);
        end else begin
            for (int i = 0; i < 9; i++) if (bus.PONER_TOPO[i]) idx = i;
        end
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (bus.PONER_TOPO != 9'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.PONER_TOPO != 9'd0) begin
            n_checks++;
            $display("FAIL wait_clear: PONER_TOPO=%h expected 0 within 50 cycles", bus.PONER_TOPO);
        end
    endtask

    task automatic wait_fin();
        int n;
        n = 0;
        while (!bus.FIN_JUEGO && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("fin_reached", 32'(bus.FIN_JUEGO), 32'd1);
    endtask

    // Shortest wrapping path: at most one move per axis
    task automatic navigate(input int idx, output int k);
        int dr, dc;
        k = 0;
        if (idx < 0) return;
        dr = (idx / 3 - cur_row + 3) % 3;
        dc = (idx % 3 - cur_col + 3) % 3;
        if (dr == 1)      begin move(4'b0100); k++; end
        else if (dr == 2) begin move(4'b1000); k++; end
        if (dc == 1)      begin move(4'b0001); k++; end
        else if (dc == 2) begin move(4'b0010); k++; end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_poner"},   32'(bus.PONER_TOPO), 32'h000);
        check({tag, "_select"},  32'(bus.SELECT),     32'h010);
        check({tag, "_golpe"},   32'(bus.GOLPE),      32'd0);
        check({tag, "_puntaje"}, 32'(bus.PUNTAJE),    32'd0);
        check({tag, "_fallos"},  32'(bus.FALLOS),     32'd0);
        check({tag, "_fin"},     32'(bus.FIN_JUEGO),  32'd0);
    endtask

    // Main instance: reset, cursor, and three games
    initial begin
        int a, b, c, d, k, n;
        bus.START = 1'b0;
        bus.BTN_GOLPE = 1'b0;
        {bus.BTN_UP, bus.BTN_DOWN, bus.BTN_LEFT, bus.BTN_RIGHT} = 4'b0000;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        // Strike outside a game is suppressed
        bus.BTN_GOLPE = 1'b1;
        @(negedge clk);
        bus.BTN_GOLPE = 1'b0;
        check("golpe_idle", 32'(bus.GOLPE), 32'd0);

        // Cursor walk with wrap and priority
        move(4'b0010);                      // cell 3
        move(4'b1000);                      // cell 0
        check("sel_cell0", 32'(bus.SELECT), 32'h001);
        move(4'b1000);                      // up from row 0 wraps to cell 6
        check("sel_cell6", 32'(bus.SELECT), 32'h040);
        move(4'b0010);                      // left from col 0 wraps to cell 8
        check("sel_cell8", 32'(bus.SELECT), 32'h100);
        move(4'b1000);                      // cell 5
        move(4'b0010);                      // cell 4
        check("sel_cell4", 32'(bus.SELECT), 32'h010);
        move(4'b1001);                      // up+right: up wins -> cell 1
        check("sel_up_right", 32'(bus.SELECT), 32'h002);
        move(4'b1111);                      // all four: up wins -> cell 7
        check("sel_all_four", 32'(bus.SELECT), 32'h080);

        // Game 1: no strikes, START during a mole is ignored
        push(8'd0, 8'd1, 1'b0, TICKS);
        push(8'd0, 8'd2, 1'b0, TICKS);
        push(8'd0, 8'd3, 1'b1, TICKS);
        pulse_start();
        wait_mole(a);
        wait_clear();
        wait_mole(b);
        pulse_start();
        wait_fin();
        check("g1_fallos", 32'(bus.FALLOS), 32'd3);
        check("g1_puntaje", 32'(bus.PUNTAJE), 32'd0);
        check("g1_poner_idle", 32'(bus.PONER_TOPO), 32'd0);

        // Game 2: hit, last-tick hit, stray hits on other cells
        push(8'd1, 8'd0, 1'b0, 0);
        push(8'd2, 8'd0, 1'b0, TICKS);
        push(8'd2, 8'd1, 1'b1, TICKS);
        pulse_start();
        check("g2_fin_cleared", 32'(bus.FIN_JUEGO), 32'd0);
        wait_mole(a);
        navigate(a, k);
        strike();
        @(negedge clk);
        check("g2_poner_after_hit", 32'(bus.PONER_TOPO), 32'd0);
        wait_mole(b);
        check("g2_new_idx_differs", 32'(b != a), 32'd1);
        navigate(b, k);
        repeat (6 - k) @(negedge clk);
        strike();                           // GOLPE lands on the timer==0 cycle
        wait_clear();
        wait_mole(c);
        stray_hit = ~bus.PONER_TOPO;
        wait_clear();
        stray_hit = '0;
        wait_fin();

        // Game 3: reset in the same cycle as a hit
        pulse_start();
        wait_mole(d);
        navigate(d, k);
        bus.BTN_GOLPE = 1'b1;
        @(negedge clk);
        bus.BTN_GOLPE = 1'b0;
        check("g3_hit_present", 32'(|(bus.HIT & bus.PONER_TOPO)), 32'd1);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        reset   = 1'b0;
        cur_row = 1;
        cur_col = 1;
        @(negedge clk);
        mon_en = 1'b1;

        n = 0;
        while (!sat_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("sat_done", 32'(sat_done), 32'd1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Saturation instance: every mole is hit at once, 255 moles in one game
    initial begin
        int n;
        bus_sat.START = 1'b0;
        bus_sat.BTN_GOLPE = 1'b0;
        {bus_sat.BTN_UP, bus_sat.BTN_DOWN, bus_sat.BTN_LEFT, bus_sat.BTN_RIGHT} = 4'b0000;
        repeat (2) @(negedge clk);
        reset_sat = 1'b0;
        bus_sat.START = 1'b1;
        @(negedge clk);
        bus_sat.START = 1'b0;
        n = 0;
        while (!bus_sat.FIN_JUEGO && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("sat_fin", 32'(bus_sat.FIN_JUEGO), 32'd1);
        check("sat_puntaje", 32'(bus_sat.PUNTAJE), 32'(SAT_EXP));
        check("sat_fallos", 32'(bus_sat.FALLOS), 32'd0);
        sat_done = 1'b1;
    end

endmodule
`default_nettype wire
